// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: instruction fetch sequencer for a combinational 64-bit ROM.
//   - Holds the PC and drives the ROM chip enable and byte address.
//   - Buffers fetched words in a small prefetch FIFO feeding decode via valid/ready.
//   - Handles branch redirect/flush and halt/resume.
//   - Shares the single ROM port with a debug reader through an alternating arbiter.
// Ports:
//   clk, rst                      clock, async active-low reset
//   rom_ce_o/rom_addr_o/rom_inst_i ROM port (data valid in the same cycle as ce)
//   inst_o/inst_pc_o/inst_valid_o/inst_ready_i  FIFO head to decode
//   branch_flag_i/branch_target_i redirect request
//   halt_i                        stop fetching
//   dbg_req_i/dbg_addr_i/dbg_ack_o/dbg_rdata_o  debug read port
module inst_fetch_ctrl #(
  parameter int                ADDR_W     = 32,
  parameter int                INST_W     = 64,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              halt_i,
  input  logic              dbg_req_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic              dbg_ack_o,
  output logic [INST_W-1:0] dbg_rdata_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HALT} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_last_dbg;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [INST_W-1:0] r_mem_inst [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_mem_pc   [FIFO_DEPTH];

  logic              w_pop;
  logic              w_space;
  logic              w_branch;
  logic              w_fetch_req;
  logic              w_dbg_req;
  logic              w_dbg_gnt;
  logic              w_fetch_gnt;
  logic [ADDR_W-1:0] w_dbg_addr;
  logic [ADDR_W-1:0] w_br_addr;

  assign inst_valid_o = (r_cnt != '0);
  assign inst_o       = inst_valid_o ? r_mem_inst[r_rd_ptr] : '0;
  assign inst_pc_o    = inst_valid_o ? r_mem_pc[r_rd_ptr]   : '0;

  assign w_pop    = inst_valid_o & inst_ready_i;
  // A slot freed by this cycle's pop counts as space, so a full FIFO
  // drained every cycle still fetches back-to-back.
  assign w_space  = (r_cnt != CNT_W'(FIFO_DEPTH)) | w_pop;
  assign w_branch = branch_flag_i & (r_state != S_BOOT);

  assign w_fetch_req = (r_state == S_FETCH) & ~halt_i & ~branch_flag_i & w_space;
  // The ROM stays idle during BOOT (and therefore during reset) for both requesters.
  assign w_dbg_req   = dbg_req_i & (r_state != S_BOOT);
  // Debug has priority except right after its own grant, so both sides progress.
  assign w_dbg_gnt   = w_dbg_req & (~w_fetch_req | ~r_last_dbg);
  assign w_fetch_gnt = w_fetch_req & ~w_dbg_gnt;

  assign w_dbg_addr = {dbg_addr_i[ADDR_W-1:3], 3'b000};
  assign w_br_addr  = {branch_target_i[ADDR_W-1:3], 3'b000};

  assign rom_ce_o   = w_fetch_gnt | w_dbg_gnt;
  assign rom_addr_o = w_fetch_gnt ? r_pc : (w_dbg_gnt ? w_dbg_addr : '0);

  // FSM, PC, arbiter history and debug response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_PC;
      r_last_dbg  <= 1'b0;
      dbg_ack_o   <= 1'b0;
      dbg_rdata_o <= '0;
    end else begin
      case (r_state)
        S_BOOT:  r_state <= S_FETCH;
        S_FETCH: if (halt_i)  r_state <= S_HALT;
        S_HALT:  if (!halt_i) r_state <= S_FETCH;
        default: r_state <= S_BOOT;
      endcase
      if (w_branch)         r_pc <= w_br_addr;
      else if (w_fetch_gnt) r_pc <= r_pc + ADDR_W'(8);
      r_last_dbg <= w_dbg_gnt;
      dbg_ack_o  <= w_dbg_gnt;
      if (w_dbg_gnt) dbg_rdata_o <= rom_inst_i;
    end
  end

  // FIFO pointers/occupancy; a branch flushes and overrides any pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (w_branch) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_fetch_gnt) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)       r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_fetch_gnt, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while counted valid.
  always_ff @(posedge clk) begin
    if (w_fetch_gnt) begin
      r_mem_inst[r_wr_ptr] <= rom_inst_i;
      r_mem_pc[r_wr_ptr]   <= r_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [63:0] rom_inst_i;
  logic [63:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        halt_i;
  logic        dbg_req_i;
  logic [31:0] dbg_addr_i;
  logic        dbg_ack_o;
  logic [63:0] dbg_rdata_o;

  inst_fetch_ctrl #(.ADDR_W(32), .INST_W(64), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_inst_i(rom_inst_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .halt_i(halt_i),
    .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i),
    .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM content: word k (byte address 8k) holds the value k.
  function automatic logic [63:0] rom_word(input logic [31:0] a);
    return {32'h0, (a >> 3)};
  endfunction

  assign rom_inst_i = rom_word(rom_addr_o);

  // ---------------- reference model ----------------
  typedef struct packed { logic [63:0] inst; logic [31:0] pc; } entry_t;
  entry_t      m_q[$];
  int          m_st;       // 0 boot, 1 fetching, 2 halted
  logic [31:0] m_pc;
  bit          m_last_dbg;
  bit          m_ack;
  logic [63:0] m_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_st       = 0;
    m_pc       = 32'h0;
    m_last_dbg = 0;
    m_ack      = 0;
    m_rdata    = '0;
  endfunction

  task automatic chk_zero(input string pfx);
    chk({pfx, ".ce"},    {63'h0, rom_ce_o},     64'h0);
    chk({pfx, ".addr"},  {32'h0, rom_addr_o},   64'h0);
    chk({pfx, ".valid"}, {63'h0, inst_valid_o}, 64'h0);
    chk({pfx, ".inst"},  inst_o,                64'h0);
    chk({pfx, ".pc"},    {32'h0, inst_pc_o},    64'h0);
    chk({pfx, ".ack"},   {63'h0, dbg_ack_o},    64'h0);
    chk({pfx, ".rdata"}, dbg_rdata_o,           64'h0);
  endtask

  // One clock cycle: check mid-cycle against the model, then advance the model.
  task automatic cycle();
    bit pop, br, space, freq, dreq, dg, fg;
    logic [31:0] eaddr, daddr;
    @(negedge clk);
    if (!rst) begin
      chk_zero("rst");
      model_reset();
    end else begin
      pop   = (m_q.size() > 0) && inst_ready_i;
      br    = branch_flag_i && (m_st != 0);
      space = (m_q.size() < DEPTH) || pop;
      freq  = (m_st == 1) && !halt_i && !branch_flag_i && space;
      dreq  = dbg_req_i && (m_st != 0);
      dg    = dreq && (!freq || !m_last_dbg);
      fg    = freq && !dg;
      daddr = dbg_addr_i & ~32'h7;
      eaddr = fg ? m_pc : (dg ? daddr : 32'h0);
      chk("rom_ce",   {63'h0, rom_ce_o},     {63'h0, (fg || dg)});
      chk("rom_addr", {32'h0, rom_addr_o},   {32'h0, eaddr});
      chk("valid",    {63'h0, inst_valid_o}, {63'h0, (m_q.size() > 0)});
      chk("inst",     inst_o,                (m_q.size() > 0) ? m_q[0].inst : 64'h0);
      chk("inst_pc",  {32'h0, inst_pc_o},    {32'h0, (m_q.size() > 0) ? m_q[0].pc : 32'h0});
      chk("dbg_ack",  {63'h0, dbg_ack_o},    {63'h0, m_ack});
      chk("dbg_rdata", dbg_rdata_o,          m_rdata);
      // advance
      if (br) begin
        m_q.delete();
        m_pc = branch_target_i & ~32'h7;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (fg) begin
          m_q.push_back('{inst: rom_word(m_pc), pc: m_pc});
          m_pc = m_pc + 32'd8;
        end
      end
      m_ack = dg;
      if (dg) m_rdata = rom_word(daddr);
      m_last_dbg = dg;
      case (m_st)
        0: m_st = 1;
        1: if (halt_i)  m_st = 2;
        2: if (!halt_i) m_st = 1;
        default: m_st = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b0; inst_ready_i = 1'b1; branch_flag_i = 1'b0; branch_target_i = '0;
    halt_i = 1'b0; dbg_req_i = 1'b0; dbg_addr_i = '0;
    model_reset();
    #2;
    chk_zero("por");
    run(2);

    // Boot and streaming fetch.
    rst = 1'b1;
    run(6);

    // Decode stalls: FIFO fills, fetch stops, PC held.
    inst_ready_i = 1'b0; run(5);
    inst_ready_i = 1'b1; run(4);

    // Branch with a full FIFO.
    inst_ready_i = 1'b0; run(3);
    inst_ready_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h43; run(1);
    branch_flag_i = 1'b0; run(4);

    // Debug read held while fetch runs: grants alternate.
    dbg_req_i = 1'b1; dbg_addr_i = 32'h2C; run(8);
    dbg_req_i = 1'b0; run(3);

    // Halt for 4 cycles, then resume.
    halt_i = 1'b1; run(4);
    halt_i = 1'b0; run(4);

    // PC wrap at the top of the address space.
    branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFF8; run(1);
    branch_flag_i = 1'b0; run(4);

    // Asynchronous reset away from any clock edge.
    #2; rst = 1'b0; #1;
    chk_zero("async_rst");
    model_reset();
    @(posedge clk); #1;
    run(1);
    rst = 1'b1; run(4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      inst_ready_i  = ($urandom % 4) != 0;
      branch_flag_i = ($urandom % 16) == 0;
      branch_target_i = $urandom;
      if (($urandom % 10) == 0) halt_i = ~halt_i;
      if (!dbg_req_i) begin
        if (($urandom % 6) == 0) begin
          dbg_req_i  = 1'b1;
          dbg_addr_i = $urandom;
        end
      end else if (m_ack && (($urandom % 4) != 0)) begin
        dbg_req_i = 1'b0;
      end
      if (!rst) rst = 1'b1;
      else if (($urandom % 500) == 0) rst = 1'b0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Sequences the 64-bit instruction ROM for the pipeline.
- Holds the PC and issues ROM chip-enable and byte address.
- Buffers fetched words in a small prefetch FIFO that feeds decode through a valid/ready handshake.
- Handles branch redirect/flush and halt/resume.
- Shares the single ROM read port with a debug/loader read requester through a fair arbiter.
- Sits between the ROM (combinational read, data valid in the same cycle) and the IF/ID stage.

Parameters:
ADDR_W, 32, instruction byte-address width
INST_W, 64, instruction word width
RESET_PC, 0, PC value loaded at reset (8-byte aligned)
FIFO_DEPTH, 2, prefetch entries (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
rom_ce_o  out  1  ROM chip enable
rom_addr_o  out  ADDR_W  ROM byte address
rom_inst_i  in  INST_W  ROM read data, same cycle as rom_ce_o
inst_o  out  INST_W  FIFO head instruction
inst_pc_o  out  ADDR_W  PC of the FIFO head
inst_valid_o  out  1  FIFO head valid
inst_ready_i  in  1  decode accepts head this cycle
branch_flag_i  in  1  redirect request
branch_target_i  in  ADDR_W  redirect address
halt_i  in  1  stop fetching
dbg_req_i  in  1  debug read request (level, held until ack)
dbg_addr_i  in  ADDR_W  debug byte address
dbg_ack_o  out  1  one-cycle pulse, dbg_rdata_o valid
dbg_rdata_o  out  INST_W  captured debug read data

Behaviour:
- Reset (rst=0, async): PC=RESET_PC, FIFO empty, state BOOT, dbg_ack_o=0, dbg_rdata_o=0, last-grant=fetch. rom_ce_o=0 and rom_addr_o=0 while in reset.
- FSM states:
  - BOOT: ROM idle for one cycle after reset release, then go to FETCH.
  - FETCH: go to HALT when halt_i=1.
  - HALT: go to FETCH when halt_i=0.
  - branch_flag_i is honoured in FETCH and HALT.
- Fetch wants the ROM when all hold: state=FETCH, halt_i=0, branch_flag_i=0, and FIFO has space. "Space" includes a slot freed by a same-cycle pop (inst_valid_o & inst_ready_i).
- Arbitration, one ROM access per cycle:
  - Only one requester active: it is granted.
  - Both active: debug wins unless debug was granted in the previous cycle; then fetch wins. Neither side starves.
- Fetch grant:
  - rom_ce_o=1, rom_addr_o=PC.
  - Push {rom_inst_i, PC} into the FIFO.
  - PC <= PC+8, wrapping modulo 2^ADDR_W.
- Debug grant:
  - rom_ce_o=1, rom_addr_o = dbg_addr_i with bits [2:0] forced to 0.
  - dbg_rdata_o <= rom_inst_i. dbg_ack_o=1 on the next cycle only.
  - The requester drops dbg_req_i in the ack cycle. A request still held during the ack cycle is treated as a new request.
- No grant: rom_ce_o=0, rom_addr_o=0.
- Pop: the head is removed when inst_valid_o & inst_ready_i. inst_o/inst_pc_o come from registers (no combinational path from rom_inst_i).
- Branch (any state except BOOT):
  - FIFO cleared; a same-cycle pop is ignored.
  - PC <= branch_target_i with bits [2:0] forced to 0.
  - No fetch push that cycle. A debug grant in the same cycle still proceeds.
  - Branch during BOOT is ignored.
- Halt: in-flight FIFO contents remain poppable. PC is frozen.
- Full FIFO with no pop: no fetch, PC holds, ROM is idle unless debug is granted.
- Push and pop in the same cycle on a full FIFO: allowed, occupancy unchanged.
- Pop on empty: no effect.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of the clock.

Test Plan:
- Reset release with RESET_PC=0, inst_ready_i=1, ROM word k = k: first rom_ce_o in cycle 2 after release, addr 0x0. Then 0x8, 0x10, ... each cycle. inst_o sequence 0,1,2 with inst_pc_o 0x0,0x8,0x10.
- inst_ready_i=0 for 5 cycles: exactly 2 fetches (PC 0x0, 0x8), then rom_ce_o=0 with PC held at 0x10. On releasing ready: heads 0x0, 0x8, then 0x10 with no gap.
- Branch to 0x43 while the FIFO holds 2 entries and ready=1: next cycle inst_valid_o=0. Next fetch addr is 0x40 and the following head has inst_pc_o=0x40. The old entries are never presented.
- dbg_req_i held with dbg_addr=0x2C while fetch runs: grants alternate debug/fetch. First debug access uses rom_addr_o=0x28. dbg_ack_o pulses one cycle later with dbg_rdata_o = word 5.
- halt_i=1 for 4 cycles: no fetch accesses, FIFO drains, PC frozen. After release, fetch resumes at the frozen PC.
- PC=2^32-8 fetched: next fetch addr is 0x0. Asserting rst mid-stream: outputs zero and FIFO empty immediately, without waiting for a clock edge.
